// File: rtl/demux1x2_32bit_stream_if.sv
// Stream handshake bundle for the 1:2 word demux.
// Source, two sink handshakes and debug counters.
interface demux1x2_32bit_stream_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             in_sel;
  logic             out0_valid;
  logic             out0_ready;
  logic [31:0]      out0_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [31:0]      out1_data;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  modport master (
    output in_valid, in_data, in_sel,
    output out0_ready, out1_ready,
    input  in_ready,
    input  out0_valid, out0_data,
    input  out1_valid, out1_data,
    input  cnt0, cnt1
  );

  modport slave (
    input  in_valid, in_data, in_sel,
    input  out0_ready, out1_ready,
    output in_ready,
    output out0_valid, out0_data,
    output out1_valid, out1_data,
    output cnt0, cnt1
  );
endinterface

// File: rtl/demux1x2_32bit_stream.sv
// 1:2 word stream demux with a small FIFO per sink.
// Per-sink accepted-word counters for debug.
module demux1x2_32bit_stream #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  demux1x2_32bit_stream_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]      mem_q  [2][DEPTH];
  logic [AW-1:0]    wptr_q [2];
  logic [AW-1:0]    wptr_d [2];
  logic [AW-1:0]    rptr_q [2];
  logic [AW-1:0]    rptr_d [2];
  logic [AW:0]      occ_q  [2];
  logic [AW:0]      occ_d  [2];
  logic [CNT_W-1:0] cnt_q  [2];
  logic [CNT_W-1:0] cnt_d  [2];

  logic [1:0] full;
  logic [1:0] valid;
  logic [1:0] push;
  logic [1:0] pop;
  logic [1:0] rdy;
  logic       in_ready;

  assign rdy = {bus.out1_ready, bus.out0_ready};

  // Handshake decode and next-state for both FIFOs; no pop look-ahead on full.
  always_comb begin
    full     = '0;
    valid    = '0;
    push     = '0;
    pop      = '0;
    in_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      full[k]  = (occ_q[k] == (AW+1)'(DEPTH));
      valid[k] = (occ_q[k] != '0);
    end
    in_ready = !full[bus.in_sel];
    for (int k = 0; k < 2; k++) begin
      push[k] = bus.in_valid && !full[k] && (bus.in_sel == 1'(k));
      pop[k]  = valid[k] && rdy[k];
      wptr_d[k] = push[k] ? wptr_q[k] + AW'(1) : wptr_q[k];
      rptr_d[k] = pop[k]  ? rptr_q[k] + AW'(1) : rptr_q[k];
      cnt_d[k]  = push[k] ? cnt_q[k] + CNT_W'(1) : cnt_q[k];
      unique case ({push[k], pop[k]})
        2'b10:   occ_d[k] = occ_q[k] + (AW+1)'(1);
        2'b01:   occ_d[k] = occ_q[k] - (AW+1)'(1);
        default: occ_d[k] = occ_q[k];
      endcase
    end
  end

  // Pointer, occupancy and counter state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        wptr_q[k] <= '0;
        rptr_q[k] <= '0;
        occ_q[k]  <= '0;
        cnt_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        wptr_q[k] <= wptr_d[k];
        rptr_q[k] <= rptr_d[k];
        occ_q[k]  <= occ_d[k];
        cnt_q[k]  <= cnt_d[k];
      end
    end
  end

  // Word storage; cleared on reset so idle heads read as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++)
        for (int e = 0; e < DEPTH; e++)
          mem_q[k][e] <= '0;
    end else begin
      for (int k = 0; k < 2; k++)
        if (push[k]) mem_q[k][wptr_q[k]] <= bus.in_data;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out0_valid = valid[0];
  assign bus.out1_valid = valid[1];
  assign bus.out0_data  = mem_q[0][rptr_q[0]];
  assign bus.out1_data  = mem_q[1][rptr_q[1]];
  assign bus.cnt0       = cnt_q[0];
  assign bus.cnt1       = cnt_q[1];
endmodule

// File: tb/tb_demux1x2_32bit_stream.sv
// Directed bench for the 1:2 word demux.
// Drives and samples on the falling edge.
module tb_demux1x2_32bit_stream;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  demux1x2_32bit_stream_if #(.CNT_W(4)) bus();

  demux1x2_32bit_stream #(.DEPTH(2), .CNT_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic s, input logic [31:0] d);
    bus.in_valid = v;
    bus.in_sel   = s;
    bus.in_data  = d;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0);
    bus.out0_ready = 1'b0;
    bus.out1_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out0_valid !== 1'b0 || bus.out1_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got %b%b exp 00",
               bus.out0_valid, bus.out1_valid);
    end
    checks++;
    if (bus.cnt0 !== 4'd0 || bus.cnt1 !== 4'd0) begin
      errors++;
      $display("FAIL reset_cnt got %h/%h exp 0/0", bus.cnt0, bus.cnt1);
    end
    checks++;
    if (bus.out0_data !== 32'h0 || bus.out1_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_data got %h/%h exp 0/0",
               bus.out0_data, bus.out1_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    bus.out0_ready = 1'b1;
    bus.out1_ready = 1'b1;
    @(negedge clk);
    drive(1'b1, 1'b0, 32'hDEADBEEF);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_rdy got %b exp 1", bus.in_ready);
    end
    checks++;
    if (bus.out0_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_nocomb got %b exp 0", bus.out0_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.out0_valid !== 1'b1 || bus.out0_data !== 32'hDEADBEEF ||
        bus.out1_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_out0 got %b %h %b exp 1 deadbeef 0",
               bus.out0_valid, bus.out0_data, bus.out1_valid);
    end
    drive(1'b1, 1'b1, 32'h12345678);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0);
    checks++;
    if (bus.out1_valid !== 1'b1 || bus.out1_data !== 32'h12345678 ||
        bus.out0_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_out1 got %b %h %b exp 1 12345678 0",
               bus.out1_valid, bus.out1_data, bus.out0_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.cnt0 !== 4'd1 || bus.cnt1 !== 4'd1 || bus.out1_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_cnt got %h/%h v1=%b exp 1/1 v1=0",
               bus.cnt0, bus.cnt1, bus.out1_valid);
    end
  endtask

  task automatic test_backpressure();
    bus.out0_ready = 1'b0;
    bus.out1_ready = 1'b0;
    drive(1'b1, 1'b0, 32'hA);
    @(negedge clk);
    drive(1'b1, 1'b0, 32'hB);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_rdy_b got %b exp 1", bus.in_ready);
    end
    @(negedge clk);
    drive(1'b1, 1'b0, 32'hC);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_full got %b exp 0", bus.in_ready);
    end
    drive(1'b1, 1'b1, 32'hC);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_sel1 got %b exp 1", bus.in_ready);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0);
    checks++;
    if (bus.out1_valid !== 1'b1 || bus.out1_data !== 32'hC ||
        bus.out0_data !== 32'hA) begin
      errors++;
      $display("FAIL bp_hold got %b %h %h exp 1 c a",
               bus.out1_valid, bus.out1_data, bus.out0_data);
    end
    bus.out0_ready = 1'b1;
    bus.out1_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.out0_valid !== 1'b1 || bus.out0_data !== 32'hB) begin
      errors++;
      $display("FAIL bp_pop_b got %b %h exp 1 b",
               bus.out0_valid, bus.out0_data);
    end
    @(negedge clk);
    checks++;
    if (bus.out0_valid !== 1'b0 || bus.out1_valid !== 1'b0 ||
        bus.cnt0 !== 4'd3 || bus.cnt1 !== 4'd2) begin
      errors++;
      $display("FAIL bp_end got %b%b %h/%h exp 00 3/2",
               bus.out0_valid, bus.out1_valid, bus.cnt0, bus.cnt1);
    end
  endtask

  task automatic test_full_pop();
    bus.out0_ready = 1'b0;
    drive(1'b1, 1'b0, 32'h100);
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h101);
    @(negedge clk);
    bus.out0_ready = 1'b1;
    drive(1'b1, 1'b0, 32'h102);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL fp_refuse got %b exp 0", bus.in_ready);
    end
    @(negedge clk);
    bus.out0_ready = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out0_data !== 32'h101) begin
      errors++;
      $display("FAIL fp_next got %b %h exp 1 101",
               bus.in_ready, bus.out0_data);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0);
    bus.out0_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.out0_valid !== 1'b1 || bus.out0_data !== 32'h102) begin
      errors++;
      $display("FAIL fp_order got %b %h exp 1 102",
               bus.out0_valid, bus.out0_data);
    end
    @(negedge clk);
    checks++;
    if (bus.out0_valid !== 1'b0 || bus.cnt0 !== 4'd6) begin
      errors++;
      $display("FAIL fp_end got %b %h exp 0 6", bus.out0_valid, bus.cnt0);
    end
  endtask

  task automatic test_wrap();
    int sent;
    int got;
    sent = 0;
    got  = 0;
    for (int c = 0; c < 100 && got < 10; c++) begin
      @(negedge clk);
      bus.out1_ready = c[0];
      drive(sent < 10, 1'b1, 32'(sent));
      if (bus.in_valid && bus.in_ready) sent++;
      if (bus.out1_valid && bus.out1_ready) begin
        checks++;
        if (bus.out1_data !== 32'(got)) begin
          errors++;
          $display("FAIL wrap_word got %h exp %h", bus.out1_data, got);
        end
        got++;
      end
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0);
    bus.out1_ready = 1'b1;
    checks++;
    if (got != 10) begin
      errors++;
      $display("FAIL wrap_count got %0d exp 10", got);
    end
    checks++;
    if (bus.cnt1 !== 4'd12 || bus.out1_valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_cnt1 got %h v=%b exp c v=0",
               bus.cnt1, bus.out1_valid);
    end
  endtask

  task automatic test_midreset();
    bus.out0_ready = 1'b0;
    drive(1'b1, 1'b0, 32'h55);
    @(negedge clk);
    drive(1'b1, 1'b1, 32'h66);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out0_valid !== 1'b0 || bus.out1_valid !== 1'b0 ||
        bus.cnt0 !== 4'd0 || bus.cnt1 !== 4'd0) begin
      errors++;
      $display("FAIL midrst got %b%b %h/%h exp 00 0/0",
               bus.out0_valid, bus.out1_valid, bus.cnt0, bus.cnt1);
    end
    checks++;
    if (bus.out0_data !== 32'h0 || bus.out1_data !== 32'h0) begin
      errors++;
      $display("FAIL midrst_data got %h/%h exp 0/0",
               bus.out0_data, bus.out1_data);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out0_valid !== 1'b0 || bus.out1_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_idle got %b%b exp 00",
               bus.out0_valid, bus.out1_valid);
    end
  endtask

  task automatic test_cnt_wrap();
    int acc;
    acc = 0;
    bus.out0_ready = 1'b1;
    for (int c = 0; c < 60 && acc < 17; c++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, 32'(c));
      if (bus.in_ready) acc++;
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0);
    checks++;
    if (acc != 17 || bus.cnt0 !== 4'd1 || bus.cnt1 !== 4'd0) begin
      errors++;
      $display("FAIL cnt_wrap got acc=%0d %h/%h exp 17 1/0",
               acc, bus.cnt0, bus.cnt1);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_full_pop();
    test_wrap();
    test_midreset();
    test_cnt_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
